// File: rtl/seq_mult_8.sv
// seq_mult_8 -- 8x8 unsigned shift-and-add multiplier, one partial product per cycle.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset
//   start    in   1   multiply request, sampled only while idle
//   a        in   8   multiplicand, captured when start is accepted
//   b        in   8   multiplier, captured when start is accepted
//   busy     out  1   high while iterating
//   done     out  1   one-cycle pulse when product holds a new result
//   product  out  16  last completed a*b, held until the next completion
//
// Operation takes 8 iterations plus one DONE cycle plus one IDLE cycle, so a
// continuously held start yields one result every 10 cycles.

// Single-bit full adder; instantiated once per bit to form the ripple stage.
module seq_mult_8_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module seq_mult_8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d;         // multiplicand
    logic [7:0]  hi_q, hi_d;       // upper half of the running product
    logic [7:0]  lo_q, lo_d;       // multiplier bits, refilled from below with product bits
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;

    // The carry flop above HI is always zero after a shift (the adder carry
    // moves into HI[7]), so it carries no information and is not stored.

    // ------------------------------------------------------------------
    // One 8-bit ripple adder: {c_out, sum} = HI + (LO[0] ? M : 0), cin = 0
    // ------------------------------------------------------------------
    logic [7:0] addend;
    logic [7:0] sum;
    logic [8:0] carry;
    logic       c_out;

    assign addend   = lo_q[0] ? m_q : 8'h00;
    assign carry[0] = 1'b0;
    assign c_out    = carry[8];

    for (genvar i = 0; i < 8; i++) begin : g_fa
        seq_mult_8_fa u_fa (
            .x  (hi_q[i]),
            .y  (addend[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == 3'd7) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs, decoded from the registered state only
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d   = a;
                    hi_d  = 8'h00;
                    lo_d  = b;
                    cnt_d = 3'd0;
                end
            end
            S_RUN: begin
                // {c_out, sum, LO} >> 1
                hi_d  = {c_out, sum[7:1]};
                lo_d  = {sum[0], lo_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                // Only the final iteration publishes, so partial sums never reach product.
                if (cnt_q == 3'd7) product_d = {c_out, sum[7:1], sum[0], lo_q[7:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= 8'h00;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            cnt_q     <= 3'd0;
            product_q <= 16'h0000;
        end else begin
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_8.sv
module tb_seq_mult_8;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;

    seq_mult_8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got product 0x%0h, want no done (cycle %0d)", product, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("product", {16'h0, product}, {16'h0, e.prod});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Count busy/done over n negedge samples.
    task automatic observe(input int n, output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
        end
    endtask

    // Issue one operation from idle; done expected 8 edges after capture.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] pe);
        int nb, nd;
        @(negedge clk);
        a = ai; b = bi; start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{pe, cyc + 8});
        @(negedge clk);
        start = 1'b0;
        nb = (busy === 1'b1) ? 1 : 0;
        nd = (done === 1'b1) ? 1 : 0;
        begin
            int b2, d2;
            observe(9, b2, d2);
            nb += b2;
            nd += d2;
        end
        chk("busy_cycles", nb, 8);
        chk("done_pulses", nd, 1);
    endtask

    initial begin
        int nb, nd;
        // Reset with start held high: reset must win.
        rst = 1'b1; start = 1'b1; a = 8'h07; b = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 16'h0000);

        // First edge after reset accepts the held start: 0x07 * 0x00.
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back('{16'h0000, cyc + 8});
        @(negedge clk);
        start = 1'b0;
        observe(9, nb, nd);
        chk("first_op_busy", nb + 1, 8);
        chk("first_op_done", nd, 1);

        run_op(8'h1F, 8'h2A, 16'h0516);
        run_op(8'h55, 8'h01, 16'h0055);
        run_op(8'h3B, 8'hA0, 16'h24E0);
        run_op(8'hFF, 8'hFF, 16'hFE01);

        // Start held continuously: one result every 10 cycles.
        @(negedge clk);
        a = 8'h10; b = 8'h10; start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{16'h0100, cyc + 8});
        exp_q.push_back('{16'h0100, cyc + 18});
        exp_q.push_back('{16'h0100, cyc + 28});
        observe(29, nb, nd);
        start = 1'b0;
        chk("held_busy", nb, 24);
        chk("held_done", nd, 3);
        observe(10, nb, nd);
        chk("held_tail_done", nd, 0);

        // Operand changes and start pulses during RUN are ignored.
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{16'h03A8, cyc + 8});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        observe(10, nb, nd);
        chk("ignore_done", nd, 1);

        // Reset 4 edges after capturing 0xFF*0xFF abandons the operation.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 16'h0000);
        rst = 1'b0;
        observe(12, nb, nd);
        chk("abort_no_done", nd, 0);
        chk("abort_idle", nb, 0);
        chk("abort_product_held", product, 16'h0000);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
